ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 97 +++++++++
 rtl/ex_stage_alu.sv | 43 ++++
 rtl/ex_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Purpose : shared field layout, ALU opcodes and register constants for the execute stage.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: id_ex_t / ex_mem_t bus layouts, bit offsets used for hazard taps,
//           ALUFun / RegDst / MemToReg codes, fixed register numbers, forwarding helper.
package ex_stage_pkg;

   localparam int ID_EX_W           = 230;
   localparam int EX_MEM_W          = 106;
   localparam int ID_EX_RT_LSB      = 69;
   localparam int ID_EX_MEMREAD_BIT = 121;

   localparam logic [5:0] ALU_ADD  = 6'b000000;
   localparam logic [5:0] ALU_SUB  = 6'b000001;
   localparam logic [5:0] ALU_AND  = 6'b011000;
   localparam logic [5:0] ALU_OR   = 6'b011110;
   localparam logic [5:0] ALU_XOR  = 6'b010110;
   localparam logic [5:0] ALU_NOR  = 6'b010001;
   localparam logic [5:0] ALU_PASSA = 6'b011010;
   localparam logic [5:0] ALU_SLL  = 6'b100000;
   localparam logic [5:0] ALU_SRL  = 6'b100001;
   localparam logic [5:0] ALU_SRA  = 6'b100011;
   localparam logic [5:0] ALU_EQ   = 6'b110011;
   localparam logic [5:0] ALU_NEQ  = 6'b110001;
   localparam logic [5:0] ALU_LT   = 6'b110101;
   localparam logic [5:0] ALU_LEZ  = 6'b111101;
   localparam logic [5:0] ALU_LTZ  = 6'b111011;
   localparam logic [5:0] ALU_GTZ  = 6'b111111;

   localparam logic [1:0] REGDST_RD = 2'b00;
   localparam logic [1:0] REGDST_RT = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;
   localparam logic [1:0] REGDST_K0 = 2'b11;

   // MemToReg is only carried through this stage; the WB stage decodes it.
   localparam logic [1:0] MEMTOREG_ALU = 2'b00;
   localparam logic [1:0] MEMTOREG_MEM = 2'b01;
   localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

   localparam logic [4:0] REG_RA = 5'd31;
   localparam logic [4:0] REG_K0 = 5'd26;

   // Declared MSB first so the packed layout matches the bus bit positions.
   typedef struct packed {
      logic [1:0]  reg_dst;        // [229:228]
      logic        branch;         // [227]
      logic [31:0] imm32;          // [226:195]
      logic [4:0]  shamt;          // [194:190]
      logic [31:0] pc_plus4;       // [189:158]
      logic        lu_op;          // [157]
      logic [31:0] lu_data;        // [156:125]
      logic [1:0]  mem_to_reg;     // [124:123]
      logic        reg_write;      // [122]
      logic        mem_read;       // [121]
      logic        mem_write;      // [120]
      logic [31:0] branch_address; // [119:88]
      logic        alu_src1;       // [87]
      logic        alu_src2;       // [86]
      logic [5:0]  alu_fun;        // [85:80]
      logic        sign;           // [79]
      logic [4:0]  rd;             // [78:74]
      logic [4:0]  rt;             // [73:69]
      logic [4:0]  rs;             // [68:64]
      logic [31:0] rt_data;        // [63:32]
      logic [31:0] rs_data;        // [31:0]
   } id_ex_t;

   typedef struct packed {
      logic [31:0] pc_plus4;       // [105:74]
      logic [1:0]  mem_to_reg;     // [73:72]
      logic        reg_write;      // [71]
      logic        mem_read;       // [70]
      logic        mem_write;      // [69]
      logic [4:0]  write_reg;      // [68:64]
      logic [31:0] store_data;     // [63:32]
      logic [31:0] result;         // [31:0]
   } ex_mem_t;

   // The MEM-stage candidate is younger than the WB-stage one, so it wins; r0 never forwards.
   function automatic logic [31:0] fwd_sel(
      input logic [4:0]  src,
      input logic [31:0] dflt,
      input logic        em_we,
      input logic [4:0]  em_rd,
      input logic [31:0] em_dat,
      input logic        mw_we,
      input logic [4:0]  mw_rd,
      input logic [31:0] mw_dat);
      if (em_we && (em_rd == src) && (src != 5'd0))
         return em_dat;
      else if (mw_we && (mw_rd == src) && (src != 5'd0))
         return mw_dat;
      else
         return dflt;
   endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Purpose : 32-bit integer ALU (arith, logic, shifts, compares) for the execute stage.
// Latency : combinational.
// Backpressure: none.
// Ports   : A, B operands; ALUFun opcode; Sign selects signed LT; Z result.
module alu
   import ex_stage_pkg::*;
(
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [5:0]  ALUFun,
   input  logic        Sign,
   output logic [31:0] Z
);

   logic lt;

   always_comb begin
      lt = Sign ? ($signed(A) < $signed(B)) : (A < B);
      Z  = 32'd0;
      case (ALUFun)
         ALU_ADD:   Z = A + B;
         ALU_SUB:   Z = A - B;
         ALU_AND:   Z = A & B;
         ALU_OR:    Z = A | B;
         ALU_XOR:   Z = A ^ B;
         ALU_NOR:   Z = ~(A | B);
         ALU_PASSA: Z = A;
         // Shifts move B; A supplies the amount (Shamt or a register).
         ALU_SLL:   Z = B << A[4:0];
         ALU_SRL:   Z = B >> A[4:0];
         ALU_SRA:   Z = $unsigned($signed(B) >>> A[4:0]);
         ALU_EQ:    Z = {31'd0, (A == B)};
         ALU_NEQ:   Z = {31'd0, (A != B)};
         ALU_LT:    Z = {31'd0, lt};
         // Zero compares are always signed and look only at A.
         ALU_LEZ:   Z = {31'd0, (A[31] | (A == 32'd0))};
         ALU_LTZ:   Z = {31'd0, A[31]};
         ALU_GTZ:   Z = {31'd0, (~A[31] & (A != 32'd0))};
         default:   Z = 32'd0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Purpose : execute stage: operand forwarding, ALU, branch resolve, EX/MEM pipeline register.
// Latency : one clk from ID_EX to EX_MEM; branch_taken/branch_target and hazard taps combinational.
// Backpressure: uart_wait=1 freezes EX_MEM; reset_b clears it asynchronously even mid-stall.
// Ports   : ID_EX (230b) in; EX_MEM_*/MEM_WB_* forwarding candidates in; uart_wait stall in;
//           ID_EX_Rt/ID_EX_MemRead hazard taps out; branch_taken/branch_target out; EX_MEM (106b) out.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                clk,
   input  logic                reset_b,
   input  logic [ID_EX_W-1:0]  ID_EX,
   input  logic [4:0]          EX_MEM_Rd,
   input  logic                EX_MEM_RegWrite,
   input  logic [31:0]         EX_MEM_RdData,
   input  logic [4:0]          MEM_WB_Rd,
   input  logic                MEM_WB_RegWrite,
   input  logic [31:0]         MEM_WB_RdData,
   input  logic                uart_wait,
   output logic [4:0]          ID_EX_Rt,
   output logic                ID_EX_MemRead,
   output logic                branch_taken,
   output logic [31:0]         branch_target,
   output logic [EX_MEM_W-1:0] EX_MEM
);

   id_ex_t      id;
   ex_mem_t     ex_mem_d, ex_mem_q;
   logic [31:0] fwd_rs, fwd_rt, op_a, op_b, alu_z;
   logic [4:0]  write_reg;

   assign id = id_ex_t'(ID_EX);

   assign ID_EX_Rt      = ID_EX[ID_EX_RT_LSB +: 5];
   assign ID_EX_MemRead = ID_EX[ID_EX_MEMREAD_BIT];

   always_comb begin
      fwd_rs = fwd_sel(id.rs, id.rs_data, EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData,
                       MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_RdData);
      fwd_rt = fwd_sel(id.rt, id.rt_data, EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData,
                       MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_RdData);
      op_a   = id.alu_src1 ? {27'd0, id.shamt} : fwd_rs;
      op_b   = id.alu_src2 ? id.imm32 : fwd_rt;
   end

   alu u_alu (
      .A      (op_a),
      .B      (op_b),
      .ALUFun (id.alu_fun),
      .Sign   (id.sign),
      .Z      (alu_z)
   );

   // Branch resolves on the raw ALU flag, before the LUI override, and ignores the stall.
   assign branch_taken  = id.branch & alu_z[0];
   assign branch_target = id.branch_address;

   always_comb begin
      write_reg = id.rd;
      case (id.reg_dst)
         REGDST_RD: write_reg = id.rd;
         REGDST_RT: write_reg = id.rt;
         REGDST_RA: write_reg = REG_RA;
         REGDST_K0: write_reg = REG_K0;
         default:   write_reg = id.rd;
      endcase
   end

   // A taken branch still writes its own entry; the downstream flush handles squashing.
   always_comb begin
      ex_mem_d = ex_mem_q;
      if (!uart_wait) begin
         ex_mem_d.pc_plus4   = id.pc_plus4;
         ex_mem_d.mem_to_reg = id.mem_to_reg;
         ex_mem_d.reg_write  = id.reg_write;
         ex_mem_d.mem_read   = id.mem_read;
         ex_mem_d.mem_write  = id.mem_write;
         ex_mem_d.write_reg  = write_reg;
         ex_mem_d.store_data = fwd_rt;
         ex_mem_d.result     = id.lu_op ? id.lu_data : alu_z;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)
         ex_mem_q <= '0;
      else
         ex_mem_q <= ex_mem_d;
   end

   assign EX_MEM = ex_mem_q;

endmodule
